// File: rtl/mx_util_pkg.sv
// Shared types and saturation-bound helpers for the MX shared-scale datapath.
package mx_util_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Largest value representable in a signed field of the given width.
    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed field of the given width.
    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/shift_sat_shl.sv
// Exact left shift of a narrow signed value into a wider signed field, clamping on overflow.
module shift_sat_shl
    import mx_util_pkg::*;
#(
    parameter int width_i     = 8,
    parameter int width_o     = 16,
    parameter int width_shift = 5
) (
    input  logic signed [width_i-1:0]     i_num,
    input  logic        [width_shift-1:0] i_shift,
    output logic signed [width_o-1:0]     o_num,
    output logic                          o_sat
);

    // Wide enough that the largest shift of any width_i value never loses bits.
    localparam int WIDTH_EXT = width_o + 2**width_shift - 1;
    localparam logic signed [WIDTH_EXT-1:0] MAX_EXT = WIDTH_EXT'(sat_max(width_o));
    localparam logic signed [WIDTH_EXT-1:0] MIN_EXT = WIDTH_EXT'(sat_min(width_o));

    logic signed [WIDTH_EXT-1:0] shifted;

    // Clamp the exact shifted value to the output range; MSB of the result flags a clamp.
    function automatic logic [width_o:0] saturate(input logic signed [WIDTH_EXT-1:0] v);
        if (v > MAX_EXT) begin
            return {1'b1, MAX_EXT[width_o-1:0]};
        end else if (v < MIN_EXT) begin
            return {1'b1, MIN_EXT[width_o-1:0]};
        end else begin
            return {1'b0, v[width_o-1:0]};
        end
    endfunction

    // Sign-extend, shift exactly, then saturate into the output width.
    always_comb begin
        shifted        = {{(WIDTH_EXT - width_i){i_num[width_i-1]}}, i_num};
        shifted        = shifted <<< i_shift;
        {o_sat, o_num} = saturate(shifted);
    end

endmodule

// File: rtl/mx_block_unpack_shl.sv
// Accepts a block of narrow signed elements with a shared left-shift and streams them out
// one per beat, widened by an exact saturating left shift.
module mx_block_unpack_shl
    import mx_util_pkg::*;
#(
    parameter int block_size  = 32,
    parameter int width_elem  = 8,
    parameter int width_o     = 16,
    parameter int width_shift = 5
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [width_shift-1:0]             i_shift,
    input  logic [block_size*width_elem-1:0]   i_elems,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic signed [width_o-1:0]          o_data,
    output logic [$clog2(block_size)-1:0]      o_idx,
    output logic                               o_last,
    output logic                               o_sat
);

    localparam int IDX_W = $clog2(block_size);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(block_size - 1);

    state_t                            state;
    state_t                            state_nxt;
    logic [IDX_W-1:0]                  idx;
    logic [IDX_W-1:0]                  idx_nxt;
    logic                              load;
    logic                              at_last;
    logic [block_size*width_elem-1:0]  elems_q;
    logic [width_shift-1:0]            shift_q;
    logic signed [width_elem-1:0]      elem_sel;
    logic signed [width_o-1:0]         data_sat;
    logic                              sat_raw;

    // Handshake and beat outputs; ready is forced low while reset is held.
    always_comb begin
        at_last  = (state == EMIT) && (idx == LAST_IDX);
        o_valid  = (state == EMIT);
        o_idx    = idx;
        o_last   = at_last;
        o_ready  = i_rst_n & ((state == IDLE) | (at_last & i_ready));
        load     = i_valid & o_ready;
        elem_sel = elems_q[int'(idx)*width_elem +: width_elem];
        o_data   = data_sat;
        o_sat    = o_valid & sat_raw;
    end

    shift_sat_shl #(
        .width_i     (width_elem),
        .width_o     (width_o),
        .width_shift (width_shift)
    ) u_shift_sat (
        .i_num   (elem_sel),
        .i_shift (shift_q),
        .o_num   (data_sat),
        .o_sat   (sat_raw)
    );

    // Next state and element index; a new block loaded on the last beat restarts at 0 with no bubble.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = EMIT;
                    idx_nxt   = '0;
                end
            end
            EMIT: begin
                if (i_ready) begin
                    if (at_last) begin
                        idx_nxt   = '0;
                        state_nxt = load ? EMIT : IDLE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Control state; async reset discards any block in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Block payload capture on acceptance only; contents are meaningless until loaded.
    always_ff @(posedge i_clk) begin
        if (load) begin
            elems_q <= i_elems;
            shift_q <= i_shift;
        end
    end

endmodule

// File: tb/tb_mx_block_unpack_shl.sv
// Randomised and directed bench for mx_block_unpack_shl with a scoreboard of expected beats.
module tb_mx_block_unpack_shl;

    localparam int BS = 4;
    localparam int WE = 8;
    localparam int WO = 16;
    localparam int WS = 5;

    logic                 clk;
    logic                 i_rst_n;
    logic                 i_valid;
    logic                 o_ready;
    logic [WS-1:0]        i_shift;
    logic [BS*WE-1:0]     i_elems;
    logic                 o_valid;
    logic                 i_ready;
    logic signed [WO-1:0] o_data;
    logic [1:0]           o_idx;
    logic                 o_last;
    logic                 o_sat;

    mx_block_unpack_shl #(
        .block_size  (BS),
        .width_elem  (WE),
        .width_o     (WO),
        .width_shift (WS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_shift (i_shift),
        .i_elems (i_elems),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_idx   (o_idx),
        .o_last  (o_last),
        .o_sat   (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint data;
        int     idx;
        bit     last;
        bit     sat;
    } beat_t;

    beat_t  exp_q[$];
    int     beat_cyc[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     beat_cnt = 0;
    int     cyc      = 0;
    bit     rand_ready = 0;

    bit              prev_stall = 0;
    logic [WO-1:0]   h_data;
    logic [1:0]      h_idx;
    logic            h_last;
    logic            h_sat;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: exact integer scaling by 2**shift, then clamp into signed 16 bits.
    task automatic model(input logic signed [WE-1:0] e, input int sh, output longint d, output bit s);
        longint v;
        v = longint'(e) * (longint'(1) << sh);
        s = 1'b0;
        d = v;
        if (v > 32767) begin
            d = 32767;
            s = 1'b1;
        end else if (v < -32768) begin
            d = -32768;
            s = 1'b1;
        end
    endtask

    function automatic logic [BS*WE-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [7:0] ea, eb, ec, ed;
        ea = a[7:0];
        eb = b[7:0];
        ec = c[7:0];
        ed = d[7:0];
        return {ed, ec, eb, ea};
    endfunction

    // Monitor/scoreboard: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (!i_rst_n) begin
            prev_stall = 0;
        end else begin
            check("valid", longint'(o_valid), longint'(exp_q.size() != 0));
            check("ready", longint'(o_ready),
                  longint'((exp_q.size() == 0) || (exp_q.size() == 1 && i_ready)));
            if (o_valid)
                check("xout", longint'($isunknown({o_data, o_idx, o_last, o_sat})), 0);
            if (prev_stall) begin
                check("hold_valid", longint'(o_valid), 1);
                check("hold_data", longint'(o_data), longint'($signed(h_data)));
                check("hold_idx", longint'(o_idx), longint'(h_idx));
                check("hold_last", longint'(o_last), longint'(h_last));
                check("hold_sat", longint'(o_sat), longint'(h_sat));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("data", longint'(o_data), b.data);
                    check("idx", longint'(o_idx), longint'(b.idx));
                    check("last", longint'(o_last), longint'(b.last));
                    check("sat", longint'(o_sat), longint'(b.sat));
                end
                beat_cnt++;
                beat_cyc.push_back(cyc);
            end
            prev_stall = o_valid && !i_ready;
            h_data = o_data;
            h_idx  = o_idx;
            h_last = o_last;
            h_sat  = o_sat;
            if (i_valid && o_ready) begin
                for (int k = 0; k < BS; k++) begin
                    beat_t nb;
                    logic signed [WE-1:0] e;
                    e = i_elems[k*WE +: WE];
                    model(e, int'(i_shift), nb.data, nb.sat);
                    nb.idx  = k;
                    nb.last = (k == BS - 1);
                    exp_q.push_back(nb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_block(input logic [BS*WE-1:0] el, input logic [WS-1:0] sh);
        bit acc;
        acc     = 0;
        i_valid = 1'b1;
        i_elems = el;
        i_shift = sh;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = o_ready;
            tick();
        end
        if (!acc) check("accept_timeout", 0, 1);
        i_valid = 1'b0;
        i_elems = $urandom;
        i_shift = WS'($urandom);
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && (exp_q.size() != 0 || o_valid); t++) tick();
        check("drain_timeout", longint'(exp_q.size() != 0 || o_valid), 0);
    endtask

    task automatic wait_idx2();
        bit seen;
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            if (o_valid && o_idx == 2) seen = 1;
            else tick();
        end
        check("reach_idx2", longint'(seen), 1);
    endtask

    initial begin
        int bc0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_elems = '0;
        i_shift = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", longint'(o_valid), 0);
        check("rst_ready", longint'(o_ready), 0);
        check("rst_last", longint'(o_last), 0);
        check("rst_sat", longint'(o_sat), 0);
        check("rst_idx", longint'(o_idx), 0);
        i_rst_n = 1'b1;
        #1;
        check("ready_after_rst", longint'(o_ready), 1);
        tick();

        // Plain block and saturating shifts
        send_block(pack4(3, -2, 127, -128), 5'd4);
        drain();
        send_block(pack4(127, -128, 3, 0), 5'd9);
        send_block(pack4(0, 1, -1, 0), 5'd31);
        drain();

        // Backpressure at idx 2 for three cycles
        bc0 = beat_cnt;
        send_block(pack4(5, -7, 100, -1), 5'd6);
        wait_idx2();
        i_ready = 1'b0;
        repeat (3) tick();
        i_ready = 1'b1;
        drain();
        check("stall_beats", longint'(beat_cnt - bc0), 4);

        // Back-to-back blocks with no bubble
        bc0 = beat_cnt;
        send_block(pack4(1, 2, 3, 4), 5'd1);
        send_block(pack4(-1, -2, -3, -4), 5'd2);
        drain();
        check("b2b_beats", longint'(beat_cnt - bc0), 8);
        if (beat_cnt - bc0 == 8)
            check("b2b_span", longint'(beat_cyc[bc0+7] - beat_cyc[bc0]), 7);

        // Reset in the middle of a block
        send_block(pack4(10, 20, 30, 40), 5'd3);
        wait_idx2();
        #2;
        i_rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", longint'(o_valid), 0);
        check("mid_rst_ready", longint'(o_ready), 0);
        check("mid_rst_idx", longint'(o_idx), 0);
        tick();
        tick();
        check("rst_hold_ready", longint'(o_ready), 0);
        check("rst_hold_valid", longint'(o_valid), 0);
        i_rst_n = 1'b1;
        #1;
        check("post_rst_ready", longint'(o_ready), 1);
        check("post_rst_valid", longint'(o_valid), 0);
        repeat (6) tick();

        // Exhaustive element x shift sweep with random backpressure
        rand_ready = 1;
        for (int sh = 0; sh < 32; sh++) begin
            for (int b = 0; b < 256; b += 4) begin
                send_block(pack4(b, b + 1, b + 2, b + 3), WS'(sh));
            end
        end
        drain();

        // Random blocks with random idle gaps
        for (int n = 0; n < 200; n++) begin
            send_block($urandom, WS'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                int gap;
                gap = $urandom_range(1, 5);
                for (int g = 0; g < gap; g++) tick();
            end
        end
        drain();
        rand_ready = 0;
        i_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
